slot_card_responder: RTL and testbench

- Card-side counterpart to the virtual slot decoder: the bus-facing end of one virtual card.
- Consumes the decoded slot selects (card_id, ioselect_n, devselect_n, iostrobe_n) plus raw bus address/rw.
- Serves Cn-page and C800 expansion ROM reads from a synchronous ROM, decodes device-register writes, and tracks C800 expansion-space ownership per Apple II rules.
- One instance per card type; output data is muxed onto the bus read path.

---
 rtl/slot_card_responder_if.sv | 33 +++
 rtl/slot_card_responder.sv | 143 ++++++++++++++
 tb/tb_slot_card_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_card_responder_if.sv
// ============================================================================
// Module   : slot_card_responder_if
// Brief    : Slot-side bus bundle between the slot decoder/bus and one card.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slot_card_responder_if;
    logic        bus_strobe;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data_in;
    logic [7:0]  card_id;
    logic        ioselect_n;
    logic        devselect_n;
    logic        iostrobe_n;
    logic [7:0]  data_out;
    logic        rd_en;

    modport master (
        output bus_strobe, addr, rw_n, data_in, card_id,
        output ioselect_n, devselect_n, iostrobe_n,
        input  data_out, rd_en
    );

    modport slave (
        input  bus_strobe, addr, rw_n, data_in, card_id,
        input  ioselect_n, devselect_n, iostrobe_n,
        output data_out, rd_en
    );
endinterface

`default_nettype wire

// File: rtl/slot_card_responder.sv
// ============================================================================
// Module   : slot_card_responder
// Brief    : Card-side responder: Cn/C800 ROM reads, device-register writes
//            and C800 expansion-space ownership. Optional C800 support is
//            enabled by defining SLOT_CARD_C8ROM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_card_responder #(
    parameter logic [7:0] CARD_ID     = 8'd1,
    parameter int         ROM_LATENCY = 1
) (
    input  wire logic          clk_logic,
    input  wire logic          system_reset,
    slot_card_responder_if.slave bus,
    output logic [11:0]        rom_addr,
    output logic               rom_rd,
    input  wire logic [7:0]    rom_data,
    output logic               reg_wr,
    output logic [3:0]         reg_addr,
    output logic [7:0]         reg_data,
    output logic               c8_owner
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_drive = 2'd2;
    localparam logic [2:0] c_rom_lat  = 3'(ROM_LATENCY);

    if (CARD_ID == 8'd0 || ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_param
        $error("slot_card_responder: illegal CARD_ID or ROM_LATENCY");
    end

    logic [1:0]  r_state;
    logic [2:0]  r_lat_cnt;
    logic [11:0] r_rom_addr;
    logic        r_rom_rd;
    logic [7:0]  r_data_out;
    logic        r_rd_en;
    logic        r_reg_wr;
    logic [3:0]  r_reg_addr;
    logic [7:0]  r_reg_data;

    logic w_match;
    logic w_cn_read;
    logic w_c8_read;
    logic w_dev_wr;

    assign w_match   = (bus.card_id == CARD_ID);
    assign w_cn_read = w_match & ~bus.ioselect_n & bus.rw_n;
    assign w_dev_wr  = w_match & ~bus.devselect_n & ~bus.rw_n;

`ifdef SLOT_CARD_C8ROM_EN
    logic r_c8_owner;
    logic w_own_set;
    logic w_own_clr;

    // The C8 read decode uses the pre-clear owner, so a CFFF read by the
    // owner is still served before ownership drops.
    assign w_c8_read = r_c8_owner & ~bus.iostrobe_n & bus.rw_n;
    assign w_own_set = w_match & ~bus.ioselect_n;
    assign w_own_clr = (bus.addr == 16'hCFFF);

    always_ff @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            r_c8_owner <= 1'b0;
        end else if (bus.bus_strobe) begin
            if (w_own_clr) begin
                r_c8_owner <= 1'b0;
            end else if (w_own_set) begin
                r_c8_owner <= 1'b1;
            end
        end
    end

    assign c8_owner = r_c8_owner;
`else
    logic w_unused;

    assign w_c8_read = 1'b0;
    assign c8_owner  = 1'b0;
    assign w_unused  = ^{bus.iostrobe_n, bus.addr[15:11]};
`endif

    always_ff @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            r_state    <= c_st_idle;
            r_lat_cnt  <= 3'd0;
            r_rom_addr <= 12'h000;
            r_rom_rd   <= 1'b0;
            r_data_out <= 8'h00;
            r_rd_en    <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_reg_addr <= 4'h0;
            r_reg_data <= 8'h00;
        end else begin
            r_rom_rd <= 1'b0;
            r_reg_wr <= 1'b0;
            if (bus.bus_strobe) begin
                // A new bus cycle always drops the read drive and abandons
                // any fetch still in flight.
                r_rd_en   <= 1'b0;
                r_lat_cnt <= 3'd0;
                if (w_cn_read) begin
                    r_rom_addr <= {4'h0, bus.addr[7:0]};
                    r_rom_rd   <= 1'b1;
                    r_state    <= c_st_wait;
                end else if (w_c8_read) begin
                    r_rom_addr <= {1'b1, bus.addr[10:0]};
                    r_rom_rd   <= 1'b1;
                    r_state    <= c_st_wait;
                end else begin
                    r_state    <= c_st_idle;
                end
                if (w_dev_wr) begin
                    r_reg_wr   <= 1'b1;
                    r_reg_addr <= bus.addr[3:0];
                    r_reg_data <= bus.data_in;
                end
            end else if (r_state == c_st_wait) begin
                if (r_lat_cnt == c_rom_lat) begin
                    r_data_out <= rom_data;
                    r_rd_en    <= 1'b1;
                    r_state    <= c_st_drive;
                end else begin
                    r_lat_cnt  <= r_lat_cnt + 3'd1;
                end
            end
        end
    end

    assign rom_addr     = r_rom_addr;
    assign rom_rd       = r_rom_rd;
    assign bus.data_out = r_data_out;
    assign bus.rd_en    = r_rd_en;
    assign reg_wr       = r_reg_wr;
    assign reg_addr     = r_reg_addr;
    assign reg_data     = r_reg_data;

endmodule

`default_nettype wire

// File: tb/tb_slot_card_responder.sv
// ============================================================================
// Module   : tb_slot_card_responder
// Brief    : Directed self-checking bench; one DUT at ROM latency 1 and one
//            at ROM latency 4 share the same bus stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slot_card_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_strobe = 1'b0;
    logic [15:0] s_addr   = 16'h0000;
    logic        s_rw_n   = 1'b1;
    logic [7:0]  s_data   = 8'h00;
    logic [7:0]  s_cid    = 8'h00;
    logic        s_ios_n  = 1'b1;
    logic        s_dev_n  = 1'b1;
    logic        s_iost_n = 1'b1;

    slot_card_responder_if bus_a ();
    slot_card_responder_if bus_b ();

    assign bus_a.bus_strobe  = s_strobe;
    assign bus_a.addr        = s_addr;
    assign bus_a.rw_n        = s_rw_n;
    assign bus_a.data_in     = s_data;
    assign bus_a.card_id     = s_cid;
    assign bus_a.ioselect_n  = s_ios_n;
    assign bus_a.devselect_n = s_dev_n;
    assign bus_a.iostrobe_n  = s_iost_n;
    assign bus_b.bus_strobe  = s_strobe;
    assign bus_b.addr        = s_addr;
    assign bus_b.rw_n        = s_rw_n;
    assign bus_b.data_in     = s_data;
    assign bus_b.card_id     = s_cid;
    assign bus_b.ioselect_n  = s_ios_n;
    assign bus_b.devselect_n = s_dev_n;
    assign bus_b.iostrobe_n  = s_iost_n;

    logic [11:0] a_rom_addr, b_rom_addr;
    logic        a_rom_rd, b_rom_rd;
    logic [7:0]  a_rom_data, b_rom_data;
    logic        a_reg_wr, b_reg_wr;
    logic [3:0]  a_reg_addr, b_reg_addr;
    logic [7:0]  a_reg_data, b_reg_data;
    logic        a_c8_owner, b_c8_owner;

    slot_card_responder #(.CARD_ID(8'd1), .ROM_LATENCY(1)) u_dut_a (
        .clk_logic(clk), .system_reset(rst), .bus(bus_a.slave),
        .rom_addr(a_rom_addr), .rom_rd(a_rom_rd), .rom_data(a_rom_data),
        .reg_wr(a_reg_wr), .reg_addr(a_reg_addr), .reg_data(a_reg_data),
        .c8_owner(a_c8_owner)
    );

    slot_card_responder #(.CARD_ID(8'd1), .ROM_LATENCY(4)) u_dut_b (
        .clk_logic(clk), .system_reset(rst), .bus(bus_b.slave),
        .rom_addr(b_rom_addr), .rom_rd(b_rom_rd), .rom_data(b_rom_data),
        .reg_wr(b_reg_wr), .reg_addr(b_reg_addr), .reg_data(b_reg_data),
        .c8_owner(b_c8_owner)
    );

    // ROM models return 8'hEE for any slot that had no rom_rd behind it.
    logic [7:0] rom_mem [0:4095];
    logic [7:0] rom_q_a = 8'h00;
    logic [7:0] pipe_b [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};

    always @(posedge clk) begin
        rom_q_a   <= a_rom_rd ? rom_mem[a_rom_addr] : 8'hEE;
        pipe_b[0] <= b_rom_rd ? rom_mem[b_rom_addr] : 8'hEE;
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign a_rom_data = rom_q_a;
    assign b_rom_data = pipe_b[3];

    int n_checks = 0;
    int n_errors = 0;
    logic exp_own;
    logic seen;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one strobe cycle; returns at the negedge inside cycle T+1.
    task automatic strobe(input logic [15:0] a, input logic rw, input logic [7:0] d,
                          input logic [7:0] cid, input logic ios, input logic dev,
                          input logic iost);
        s_addr = a; s_rw_n = rw; s_data = d; s_cid = cid;
        s_ios_n = ios; s_dev_n = dev; s_iost_n = iost;
        s_strobe = 1'b1;
        @(negedge clk);
        s_strobe = 1'b0; s_ios_n = 1'b1; s_dev_n = 1'b1; s_iost_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i * 13 + 7);
        rom_mem[12'h005] = 8'hA9;
        rom_mem[12'h012] = 8'h6D;
        rom_mem[12'h9AB] = 8'h5C;
        rom_mem[12'hFFF] = 8'hC3;
`ifdef SLOT_CARD_C8ROM_EN
        exp_own = 1'b1;
`else
        exp_own = 1'b0;
`endif

        idle(3);
        check("rst_rom_addr", 16'(a_rom_addr), 16'h0);
        check("rst_rom_rd",   16'(a_rom_rd),   16'h0);
        check("rst_data_out", 16'(bus_a.data_out), 16'h0);
        check("rst_rd_en",    16'(bus_a.rd_en), 16'h0);
        check("rst_reg_wr",   16'(a_reg_wr),   16'h0);
        check("rst_reg_addr", 16'(a_reg_addr), 16'h0);
        check("rst_reg_data", 16'(a_reg_data), 16'h0);
        check("rst_c8_owner", 16'(a_c8_owner), 16'h0);
        check("rst_b_rd_en",  16'(bus_b.rd_en), 16'h0);
        rst = 1'b0;
        idle(2);

        // Cn read C305
        strobe(16'hC305, 1'b1, 8'h00, 8'd1, 1'b0, 1'b1, 1'b1);
        check("cn_a_rom_rd_t1",   16'(a_rom_rd),   16'h1);
        check("cn_a_rom_addr",    16'(a_rom_addr), 16'h005);
        check("cn_a_rd_en_t1",    16'(bus_a.rd_en), 16'h0);
        check("cn_b_rom_rd_t1",   16'(b_rom_rd),   16'h1);
        check("cn_b_rom_addr",    16'(b_rom_addr), 16'h005);
        check("cn_a_owner_t1",    16'(a_c8_owner), 16'(exp_own));
        idle(1);
        check("cn_a_rom_rd_t2",   16'(a_rom_rd),   16'h0);
        check("cn_a_rd_en_t2",    16'(bus_a.rd_en), 16'h0);
        idle(1);
        check("cn_a_rd_en_t3",    16'(bus_a.rd_en), 16'h1);
        check("cn_a_data_t3",     16'(bus_a.data_out), 16'hA9);
        check("cn_b_rd_en_t3",    16'(bus_b.rd_en), 16'h0);
        idle(2);
        check("cn_b_rd_en_t5",    16'(bus_b.rd_en), 16'h0);
        idle(1);
        check("cn_b_rd_en_t6",    16'(bus_b.rd_en), 16'h1);
        check("cn_b_data_t6",     16'(bus_b.data_out), 16'hA9);
        check("cn_a_hold_t6",     16'(bus_a.rd_en), 16'h1);
        idle(2);

`ifdef SLOT_CARD_C8ROM_EN
        strobe(16'hC9AB, 1'b1, 8'h00, 8'd1, 1'b1, 1'b1, 1'b0);
        check("c8_a_rom_rd",      16'(a_rom_rd),   16'h1);
        check("c8_a_rom_addr",    16'(a_rom_addr), 16'h9AB);
        check("c8_a_rd_en_t1",    16'(bus_a.rd_en), 16'h0);
        idle(2);
        check("c8_a_data",        16'(bus_a.data_out), 16'h5C);
        check("c8_a_rd_en_t3",    16'(bus_a.rd_en), 16'h1);
        idle(3);
        check("c8_b_data",        16'(bus_b.data_out), 16'h5C);
        idle(2);
        strobe(16'hCFFF, 1'b1, 8'h00, 8'd1, 1'b1, 1'b1, 1'b0);
        check("cfff_a_rom_addr",  16'(a_rom_addr), 16'hFFF);
        check("cfff_a_rom_rd",    16'(a_rom_rd),   16'h1);
        check("cfff_a_owner",     16'(a_c8_owner), 16'h0);
        check("cfff_b_owner",     16'(b_c8_owner), 16'h0);
        idle(2);
        check("cfff_a_data",      16'(bus_a.data_out), 16'hC3);
        idle(5);
        strobe(16'hC9AB, 1'b1, 8'h00, 8'd1, 1'b1, 1'b1, 1'b0);
        check("c8x_a_rom_rd",     16'(a_rom_rd),   16'h0);
        check("c8x_a_owner",      16'(a_c8_owner), 16'h0);
        check("c8x_a_rom_addr",   16'(a_rom_addr), 16'hFFF);
        idle(2);
        check("c8x_a_rd_en",      16'(bus_a.rd_en), 16'h0);
        idle(5);
`else
        strobe(16'hC9AB, 1'b1, 8'h00, 8'd1, 1'b1, 1'b1, 1'b0);
        check("noc8_a_rom_rd",    16'(a_rom_rd),   16'h0);
        check("noc8_a_owner",     16'(a_c8_owner), 16'h0);
        check("noc8_a_rom_addr",  16'(a_rom_addr), 16'h005);
        check("noc8_a_rd_en_t1",  16'(bus_a.rd_en), 16'h0);
        idle(2);
        check("noc8_a_rd_en_t3",  16'(bus_a.rd_en), 16'h0);
        idle(5);
`endif

        // Device write C0B3
        strobe(16'hC0B3, 1'b0, 8'h7E, 8'd1, 1'b1, 1'b0, 1'b1);
        check("dw_a_reg_wr",      16'(a_reg_wr),   16'h1);
        check("dw_a_reg_addr",    16'(a_reg_addr), 16'h3);
        check("dw_a_reg_data",    16'(a_reg_data), 16'h7E);
        check("dw_a_rom_rd",      16'(a_rom_rd),   16'h0);
        check("dw_b_reg_wr",      16'(b_reg_wr),   16'h1);
        idle(1);
        check("dw_a_reg_wr_t2",   16'(a_reg_wr),   16'h0);
        idle(6);

        // Matched read then the same read from a non-matching card
        strobe(16'hC312, 1'b1, 8'h00, 8'd1, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("cn2_a_data",       16'(bus_a.data_out), 16'h6D);
        check("cn2_a_rd_en",      16'(bus_a.rd_en), 16'h1);
        idle(5);
        strobe(16'hC305, 1'b1, 8'h00, 8'd2, 1'b0, 1'b1, 1'b1);
        check("mm_a_rom_rd",      16'(a_rom_rd),   16'h0);
        check("mm_a_rd_en",       16'(bus_a.rd_en), 16'h0);
        check("mm_a_rom_addr",    16'(a_rom_addr), 16'h012);
        check("mm_a_owner",       16'(a_c8_owner), 16'(exp_own));
        idle(2);
        check("mm_a_rd_en_t3",    16'(bus_a.rd_en), 16'h0);
        idle(5);

        // Abort: second strobe two cycles after a read
        strobe(16'hC300, 1'b1, 8'h00, 8'd1, 1'b0, 1'b1, 1'b1);
        check("ab_b_rom_rd",      16'(b_rom_rd),   16'h1);
        idle(1);
        strobe(16'hC0B0, 1'b0, 8'h11, 8'd1, 1'b1, 1'b0, 1'b1);
        check("ab_b_reg_wr",      16'(b_reg_wr),   16'h1);
        check("ab_b_reg_addr",    16'(b_reg_addr), 16'h0);
        check("ab_b_reg_data",    16'(b_reg_data), 16'h11);
        seen = 1'b0;
        repeat (10) begin
            if (bus_a.rd_en || bus_b.rd_en) seen = 1'b1;
            @(negedge clk);
        end
        check("ab_no_rd_en",      16'(seen), 16'h0);

        // Reset in the middle of a latency-4 fetch
        strobe(16'hC300, 1'b1, 8'h00, 8'd1, 1'b0, 1'b1, 1'b1);
        check("rw_b_rom_rd",      16'(b_rom_rd),   16'h1);
        idle(1);
        rst = 1'b1;
        #1;
        check("rw_b_rom_addr",    16'(b_rom_addr), 16'h0);
        check("rw_b_rd_en",       16'(bus_b.rd_en), 16'h0);
        check("rw_b_data_out",    16'(bus_b.data_out), 16'h0);
        check("rw_b_reg_data",    16'(b_reg_data), 16'h0);
        check("rw_b_owner",       16'(b_c8_owner), 16'h0);
        idle(2);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (bus_b.rd_en || b_rom_rd) seen = 1'b1;
            @(negedge clk);
        end
        check("rw_no_rd_after",   16'(seen), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
